// File: rtl/sum13_accum_sched.sv
// sum13_accum_sched
//   Multi-beat reduction controller for the modular squarer. It takes a job of
//   up to MAX_BEATS beats. Each beat carries 13 N-bit lanes. The lanes are
//   reduced by a 13:1 summer, registered into stage 1, and then accumulated
//   into an ACC_W-bit total. The total is handed on through a valid/ready
//   output.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   reset      : asynchronous, active-high reset
//   start      : job start pulse; acted on only in IDLE
//   num_beats  : beat count for the job; values above MAX_BEATS are clamped
//   busy       : high whenever the controller is not IDLE
//   in_valid   : beat data valid
//   in_ready   : high while beats are being collected
//   in_vect    : 13 lanes of N-bit data
//   in_mask    : per-lane enable; a masked-off lane contributes zero
//   out_valid  : job total valid, held until out_ready
//   out_ready  : consumer accepts the total
//   out_sum    : job total; keeps its value until the next start

// Combinational 13:1 unsigned summer. The result is N+4 bits wide, because
// 13*(2^N-1) < 2^(N+4). USE_DENSE_ADDERS selects a balanced adder tree, which
// is shallower. Otherwise a simple ripple chain of adds is used.
module sum13to1 #(
  parameter int N                = 32,
  parameter bit USE_DENSE_ADDERS = 1'b1
) (
  input  logic [N-1:0] lanes [13],
  output logic [N+3:0] sum
);

  generate
    if (USE_DENSE_ADDERS) begin : g_tree
      logic [N+3:0] lvl0 [13];
      logic [N+3:0] lvl1 [7];
      logic [N+3:0] lvl2 [4];
      logic [N+3:0] lvl3 [2];

      always_comb begin
        for (int i = 0; i < 13; i++) begin
          lvl0[i] = {4'b0000, lanes[i]};
        end
        // 13 -> 7: six pairs plus lane 12 passed through
        for (int i = 0; i < 6; i++) begin
          lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
        end
        lvl1[6] = lvl0[12];
        // 7 -> 4
        for (int i = 0; i < 3; i++) begin
          lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
        end
        lvl2[3] = lvl1[6];
        // 4 -> 2 -> 1
        lvl3[0] = lvl2[0] + lvl2[1];
        lvl3[1] = lvl2[2] + lvl2[3];
        sum     = lvl3[0] + lvl3[1];
      end
    end else begin : g_chain
      always_comb begin
        sum = '0;
        for (int i = 0; i < 13; i++) begin
          sum = sum + {4'b0000, lanes[i]};
        end
      end
    end
  endgenerate

endmodule

module sum13_accum_sched #(
  parameter  int N                = 32,
  parameter  int MAX_BEATS        = 16,
  parameter  bit USE_DENSE_ADDERS = 1'b1,
  localparam int BW               = $clog2(MAX_BEATS) + 1,
  localparam int ACC_W            = N + 4 + $clog2(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BW-1:0]    num_beats,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vect [13],
  input  logic [12:0]      in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BEATS);

  state_t            state;
  state_t            state_nxt;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     beats_clamped;
  logic              accept;
  logic              start_idle;

  logic [N-1:0]      lanes_p0 [13];
  logic [N+3:0]      sum_p0;
  logic [N+3:0]      sum_p1;
  logic              vld_p1;
  logic [ACC_W-1:0]  acc;

  // in_ready is registered. It is high exactly while state == LOAD, so a
  // handshake can only happen in LOAD.
  assign accept        = in_valid & in_ready;
  assign start_idle    = (state == IDLE) & start;
  assign beats_clamped = (num_beats > MAX_CNT) ? MAX_CNT : num_beats;
  assign out_sum       = acc;

  // Stage 0: mask the lanes and reduce them combinationally
  always_comb begin
    for (int i = 0; i < 13; i++) begin
      lanes_p0[i] = in_mask[i] ? in_vect[i] : '0;
    end
  end

  sum13to1 #(
    .N                (N),
    .USE_DENSE_ADDERS (USE_DENSE_ADDERS)
  ) u_sum13 (
    .lanes (lanes_p0),
    .sum   (sum_p0)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_beats == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        // The counter is never zero in LOAD. The beat that consumes the
        // last count moves the job to DRAIN.
        if (accept && (beat_cnt == BW'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The state register and the handshake outputs are all driven from flops.
  // The outputs are decoded from state_nxt, so they line up with the state
  // and cannot glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != IDLE);
      in_ready  <= (state_nxt == LOAD);
      out_valid <= (state_nxt == DONE);
      if (start_idle) begin
        beat_cnt <= beats_clamped;
      end else if (accept) begin
        beat_cnt <= beat_cnt - BW'(1);
      end
    end
  end

  // Stage 1: register the 13:1 sum of each accepted beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        sum_p1 <= sum_p0;
      end
    end
  end

  // Stage 2: accumulate. A start clears the total. vld_p1 is always low in
  // IDLE, because DRAIN has already consumed the last stage-1 value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (start_idle) begin
      acc <= '0;
    end else if (vld_p1) begin
      acc <= acc + ACC_W'(sum_p1);
    end
  end

endmodule

// File: tb/tb_sum13_accum_sched.sv
// tb_sum13_accum_sched
//   Directed bench for sum13_accum_sched with N=32 and MAX_BEATS=16. Every
//   expected value below is worked out by hand from the lane data.
module tb_sum13_accum_sched;

  localparam int N     = 32;
  localparam int BW    = 5;
  localparam int ACC_W = 40;

  logic             clk;
  logic             reset;
  logic             start;
  logic [BW-1:0]    num_beats;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_vect [13];
  logic [12:0]      in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;

  int n_checks;
  int n_errors;

  sum13_accum_sched #(
    .N                (N),
    .MAX_BEATS        (16),
    .USE_DENSE_ADDERS (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_beats (num_beats),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vect   (in_vect),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lanes(input logic [N-1:0] v);
    for (int i = 0; i < 13; i++) in_vect[i] = v;
  endtask

  task automatic start_job(input logic [BW-1:0] nb);
    num_beats = nb;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic out_handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    start     = 1'b0;
    num_beats = '0;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    set_lanes('0);
    step();
    step();
    chk("rst_busy",      busy,      0);
    chk("rst_in_ready",  in_ready,  0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum",   out_sum,   0);
    reset = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Single beat: lanes 1..13 sum to 91
    start_job(5'd1);
    chk("t1_busy",     busy,     1);
    chk("t1_in_ready", in_ready, 1);
    for (int i = 0; i < 13; i++) in_vect[i] = 32'(i + 1);
    in_mask  = 13'h1FFF;
    in_valid = 1'b1;
    step();                        // beat handshake edge k
    in_valid = 1'b0;
    chk("t1_ov_k",     out_valid, 0);
    chk("t1_ready_k",  in_ready,  0);
    step();                        // edge k+1
    chk("t1_ov_k1",    out_valid, 1);
    chk("t1_sum",      out_sum,   91);
    chk("t1_busy_dn",  busy,      1);
    out_handshake();
    chk("t1_ov_after", out_valid, 0);
    chk("t1_busy_off", busy,      0);
    chk("t1_sum_hold", out_sum,   91);

    // Max job with a start pulse while busy, then backpressure in DONE
    start_job(5'd16);
    set_lanes(32'hFFFF_FFFF);
    in_valid = 1'b1;
    for (int b = 0; b < 16; b++) begin
      if (b == 5) begin
        start     = 1'b1;          // ignored: not IDLE
        num_beats = 5'd1;
      end
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    chk("t2_ready_low", in_ready,  0);
    chk("t2_ov_early",  out_valid, 0);
    step();
    chk("t2_ov",        out_valid, 1);
    chk("t2_sum",       out_sum,   40'hCF_FFFF_FF30);
    for (int i = 0; i < 5; i++) step();
    chk("t2_ov_held",   out_valid, 1);
    chk("t2_sum_held",  out_sum,   40'hCF_FFFF_FF30);
    // start coinciding with out_ready in DONE is ignored
    start     = 1'b1;
    num_beats = 5'd2;
    out_handshake();
    start     = 1'b0;
    chk("t2_busy_off",  busy,      0);
    chk("t2_ov_off",    out_valid, 0);
    step();
    chk("t2_still_idle", busy,     0);

    // Zero-beat job: result 0 one edge after start
    start_job(5'd0);
    chk("t3_ov",  out_valid, 1);
    chk("t3_sum", out_sum,   0);
    out_handshake();
    chk("t3_busy_off", busy, 0);

    // Masking and stalls: only lane 0 (5) counts, 3 beats -> 15
    start_job(5'd3);
    set_lanes(32'd5);
    in_mask = 13'h0001;
    begin
      logic pat [6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
        in_valid = pat[i];
        if (in_ready && in_valid) cnt++;
        if (i == 2) chk("t4_ready_gap", in_ready, 1);
        step();
      end
    end
    in_valid = 1'b0;
    chk("t4_beats",    cnt,      3);
    chk("t4_ready_lo", in_ready, 0);
    step();
    chk("t4_ov",  out_valid, 1);
    chk("t4_sum", out_sum,   15);
    out_handshake();

    // Clamp: 20 requested -> 16 accepted, 16*13 = 208
    start_job(5'd20);
    set_lanes(32'd1);
    in_mask  = 13'h1FFF;
    in_valid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready) cnt++;
      step();
      if (!in_ready) break;
    end
    in_valid = 1'b0;
    chk("t5_beats",    cnt,      16);
    chk("t5_ready_lo", in_ready, 0);
    step();
    chk("t5_ov",  out_valid, 1);
    chk("t5_sum", out_sum,   208);
    out_handshake();

    // Reset mid-LOAD after 2 of 4 beats
    start_job(5'd4);
    set_lanes(32'd7);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_busy",     busy,      0);
    chk("t6_in_ready", in_ready,  0);
    chk("t6_ov",       out_valid, 0);
    step();
    reset = 1'b0;
    step();
    chk("t6_ov_after", out_valid, 0);
    start_job(5'd1);
    set_lanes(32'd2);
    in_mask  = 13'h1FFF;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t6_ov_new",  out_valid, 1);
    chk("t6_sum_new", out_sum,   26);
    out_handshake();
    chk("t6_busy_off", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
